instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC generation, in-order memory requests, a DEPTH-entry
// response buffer toward decode, and redirect handling with stale-response discard.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        Clk_i,
    input  logic        Rst_ni,
    output logic        IMemReq_o,
    output logic [31:0] IMemAddr_o,
    input  logic        IMemGnt_i,
    input  logic        IMemRvalid_i,
    input  logic [31:0] IMemRdata_i,
    input  logic        Redirect_i,
    input  logic [31:0] RedirectPC_i,
    output logic [31:0] Instruction_o,
    output logic [31:0] InstrPC_o,
    output logic        InstrValid_o,
    input  logic        InstrReady_i
);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic {FETCH, DRAIN} state_e;

    state_e        state_q, state_d;
    logic          started_q;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outs_q, outs_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] head_q, head_d;
    logic [31:0]   buf_instr_q [DEPTH];
    logic [31:0]   buf_pc_q    [DEPTH];

    logic          grant;
    logic          handshake;
    logic          push;
    logic [PW-1:0] tail;
    logic [CW:0]   occupancy;
    logic [31:0]   redirect_pc;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= int'(DEPTH)) s = s - int'(DEPTH);
        return PW'(s);
    endfunction

    assign redirect_pc  = RedirectPC_i & ~32'h3;
    assign InstrValid_o = (cnt_q != '0);
    assign handshake    = InstrValid_o & InstrReady_i;
    // The slot freed by this cycle's pop is reusable at once, so DEPTH=2 sustains one word per cycle.
    assign occupancy    = {1'b0, outs_q} + {1'b0, cnt_q} - {{CW{1'b0}}, handshake};
    assign IMemReq_o    = started_q & (state_q == FETCH) & (occupancy < DEPTH_C);
    assign IMemAddr_o   = pc_q;
    assign grant        = IMemReq_o & IMemGnt_i;
    assign push         = IMemRvalid_i & (state_q == FETCH) & ~Redirect_i;
    assign tail         = wrap_add(head_q, cnt_q);

    assign Instruction_o = InstrValid_o ? buf_instr_q[head_q] : NOP;
    assign InstrPC_o     = InstrValid_o ? buf_pc_q[head_q]    : 32'h0;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outs_d   = outs_q;
        disc_d   = disc_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        if (grant)     pc_d   = pc_q + 32'd4;
        if (handshake) head_d = wrap_add(head_q, CW'(1));
        if (Redirect_i) begin
            // Everything still in flight, including this cycle's grant, becomes stale.
            pc_d     = redirect_pc;
            rsp_pc_d = redirect_pc;
            cnt_d    = '0;
            outs_d   = '0;
            disc_d   = outs_q + disc_q + CW'(grant) - CW'(IMemRvalid_i);
            state_d  = (disc_d != '0) ? DRAIN : FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    outs_d = outs_q + CW'(grant) - CW'(IMemRvalid_i);
                    cnt_d  = cnt_q + CW'(push) - CW'(handshake);
                    if (push) rsp_pc_d = rsp_pc_q + 32'd4;
                end
                DRAIN: begin
                    disc_d = disc_q - CW'(IMemRvalid_i);
                    cnt_d  = cnt_q - CW'(handshake);
                    if (disc_d == '0) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state_q   <= FETCH;
            started_q <= 1'b0;
            pc_q      <= RESET_PC;
            rsp_pc_q  <= RESET_PC;
            outs_q    <= '0;
            disc_q    <= '0;
            cnt_q     <= '0;
            head_q    <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            outs_q    <= outs_d;
            disc_q    <= disc_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (push) begin
            buf_instr_q[tail] <= IMemRdata_i;
            buf_pc_q[tail]    <= rsp_pc_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with per-request latency, and a
// program-order stream model (sequential PCs restarted at every redirect target).
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        Rst_ni;
    logic        IMemReq_o;
    logic [31:0] IMemAddr_o;
    logic        IMemGnt_i;
    logic        IMemRvalid_i;
    logic [31:0] IMemRdata_i;
    logic        Redirect_i;
    logic [31:0] RedirectPC_i;
    logic [31:0] Instruction_o;
    logic [31:0] InstrPC_o;
    logic        InstrValid_o;
    logic        InstrReady_i;

    instr_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .Clk_i(clk), .Rst_ni(Rst_ni),
        .IMemReq_o(IMemReq_o), .IMemAddr_o(IMemAddr_o), .IMemGnt_i(IMemGnt_i),
        .IMemRvalid_i(IMemRvalid_i), .IMemRdata_i(IMemRdata_i),
        .Redirect_i(Redirect_i), .RedirectPC_i(RedirectPC_i),
        .Instruction_o(Instruction_o), .InstrPC_o(InstrPC_o),
        .InstrValid_o(InstrValid_o), .InstrReady_i(InstrReady_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        memq[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_hs = 0;
    logic [31:0] exp_pc, exp_req_addr;
    bit          draining, exp_req_next, hold_req, stall_hold, after_redirect;
    logic [31:0] held_addr, held_instr, held_pc;
    bit          last_hs, last_req, last_gnt, last_rv;
    logic [31:0] last_hs_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_model();
        memq.delete();
        exp_pc = RST_PC;
        exp_req_addr = RST_PC;
        draining = 0; hold_req = 0; stall_hold = 0; after_redirect = 0;
        exp_req_next = 1;
    endtask

    task automatic do_reset();
        Rst_ni = 1'b0;
        IMemGnt_i = 0; IMemRvalid_i = 0; IMemRdata_i = 0;
        Redirect_i = 0; RedirectPC_i = 0; InstrReady_i = 0;
        #1;
        chk("rst_req", IMemReq_o, 0);
        chk("rst_addr", IMemAddr_o, RST_PC);
        chk("rst_valid", InstrValid_o, 0);
        chk("rst_instr", Instruction_o, NOP);
        chk("rst_pc", InstrPC_o, 0);
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        Rst_ni = 1'b1;
        #1;
        chk("req_at_release", IMemReq_o, 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    // One cycle: drive inputs at the falling edge, check, then advance both models.
    task automatic tick(input bit g, input bit r, input bit rd, input logic [31:0] tgt);
        bit   rv, gr, hs;
        int   stale_n;
        req_t e;
        rv = (memq.size() != 0) && (memq[0].due <= cyc);
        IMemRvalid_i = rv;
        IMemRdata_i  = rv ? memf(memq[0].addr) : $urandom;
        IMemGnt_i    = g;
        InstrReady_i = r;
        Redirect_i   = rd;
        RedirectPC_i = tgt;
        #1;
        if (draining) chk("drain_no_req", IMemReq_o, 0);
        if (exp_req_next) begin
            chk("restart_req", IMemReq_o, 1);
            chk("restart_addr", IMemAddr_o, exp_req_addr);
        end
        if (hold_req) begin
            chk("hold_req", IMemReq_o, 1);
            chk("hold_addr", IMemAddr_o, held_addr);
        end
        if (after_redirect) chk("flush_valid", InstrValid_o, 0);
        if (stall_hold) begin
            chk("stall_valid", InstrValid_o, 1);
            chk("stall_instr", Instruction_o, held_instr);
            chk("stall_pc", InstrPC_o, held_pc);
        end
        if (InstrValid_o !== 1'b1) chk("nop_when_idle", Instruction_o, NOP);
        if (IMemReq_o) chk("addr_align", {30'b0, IMemAddr_o[1:0]}, 0);
        gr = IMemReq_o & g;
        if (gr) chk("grant_addr", IMemAddr_o, exp_req_addr);
        hs = InstrValid_o & r;
        if (hs) begin
            chk("deliver_pc", InstrPC_o, exp_pc);
            chk("deliver_instr", Instruction_o, memf(exp_pc));
        end

        hold_req = IMemReq_o & ~g & ~rd;
        held_addr = IMemAddr_o;
        stall_hold = InstrValid_o & ~r & ~rd;
        held_instr = Instruction_o;
        held_pc = InstrPC_o;
        after_redirect = rd;
        if (rv) void'(memq.pop_front());
        if (gr) begin
            e.addr = IMemAddr_o; e.due = cyc + lat; e.stale = 1'b0;
            memq.push_back(e);
        end
        if (rd) foreach (memq[i]) memq[i].stale = 1'b1;
        stale_n = 0;
        foreach (memq[i]) if (memq[i].stale) stale_n++;
        exp_req_next = (rd || draining) && (stale_n == 0);
        draining = (stale_n != 0);
        if (hs) exp_pc = exp_pc + 32'd4;
        if (rd) exp_pc = tgt & ~32'h3;
        if (gr) exp_req_addr = exp_req_addr + 32'd4;
        if (rd) exp_req_addr = tgt & ~32'h3;
        last_hs = hs; last_hs_pc = InstrPC_o; last_req = IMemReq_o; last_gnt = gr; last_rv = rv;
        if (hs) n_hs++;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_hs(input string tag, input logic [31:0] pc_exp);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1, 1, 0, 0);
            found = last_hs;
        end
        chk({tag, "_seen"}, {31'b0, found}, 1);
        if (found) chk({tag, "_pc"}, last_hs_pc, pc_exp);
    endtask

    initial begin
        bit found;
        int hs0;
        Rst_ni = 1'b1;
        IMemGnt_i = 0; IMemRvalid_i = 0; IMemRdata_i = 0;
        Redirect_i = 0; RedirectPC_i = 0; InstrReady_i = 0;
        #2;
        do_reset();

        // Streaming from RESET_PC with a 1-cycle memory and ready held high.
        lat = 1;
        repeat (4) tick(1, 1, 0, 0);
        hs0 = n_hs;
        repeat (20) tick(1, 1, 0, 0);
        chk("throughput", n_hs - hs0, 20);

        // Decode stall: requests stop once buffer plus in-flight reach DEPTH.
        repeat (5) tick(1, 0, 0, 0);
        chk("stall_req_drop", {31'b0, last_req}, 0);
        repeat (10) tick(1, 1, 0, 0);

        // 3-cycle memory, redirect with two requests in flight.
        lat = 3;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (memq.size() == 2 && memq[0].due > cyc) begin
                tick(1, 1, 1, 32'h0000_0200);
                found = 1;
            end else begin
                tick(1, 1, 0, 0);
            end
        end
        chk("drain_setup", {31'b0, found}, 1);
        wait_hs("drain_first", 32'h0000_0200);

        // Redirect coincident with grant, response and handshake.
        lat = 1;
        repeat (6) tick(1, 1, 0, 0);
        tick(1, 1, 1, 32'h0000_0300);
        chk("coinc_hs", {31'b0, last_hs}, 1);
        chk("coinc_gnt", {31'b0, last_gnt}, 1);
        chk("coinc_rv", {31'b0, last_rv}, 1);
        wait_hs("coinc_first", 32'h0000_0300);

        // Misaligned target is forced to a word address.
        repeat (4) tick(0, 1, 0, 0);
        tick(0, 1, 1, 32'h0000_0203);
        chk("align_req", IMemReq_o, 1);
        chk("align_addr", IMemAddr_o, 32'h0000_0200);

        // PC wraps from the top of the address space.
        repeat (4) tick(0, 1, 0, 0);
        tick(0, 1, 1, 32'hFFFF_FFFC);
        tick(1, 1, 0, 0);
        chk("wrap_gnt", {31'b0, last_gnt}, 1);
        chk("wrap_addr", IMemAddr_o, 32'h0000_0000);
        wait_hs("wrap_first", 32'hFFFF_FFFC);
        wait_hs("wrap_second", 32'h0000_0000);

        // Random traffic: grants, stalls, latencies and redirects.
        hs0 = n_hs;
        for (int i = 0; i < 1500; i++) begin
            lat = $urandom_range(1, 4);
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0, $urandom);
        end
        chk("random_progress", {31'b0, (n_hs - hs0) >= 100}, 1);

        // Asynchronous reset in the middle of traffic.
        lat = 1;
        repeat (3) tick(1, 1, 0, 0);
        #3;
        do_reset();
        wait_hs("post_reset", RST_PC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
